led_rate_decoder: RTL
=====================

Name: led_rate_decoder

Overview:
- Receive-side counterpart of the LED blinker. Samples an LED drive line, measures the half-period between toggles, and decodes which of the four blink rates (100/50/10/1 Hz) is present.
- Reports the rate using the same 2-bit code as the blinker's switch-select inputs.
- Used on test fixtures and loopback boards to check the blinker's output.
- Flags a steady (non-toggling) line as lost.

Parameters:
- c_CNT_100HZ, 125, nominal half-period in clocks for 100 Hz
- c_CNT_50HZ, 250, nominal half-period for 50 Hz
- c_CNT_10HZ, 1250, nominal half-period for 10 Hz
- c_CNT_1HZ, 12500, nominal half-period for 1 Hz
- c_TOL_SHIFT, 3, tolerance = nominal >> c_TOL_SHIFT (12.5 %)
- c_LOCK_CNT, 2, consecutive matching half-periods required for lock (range 1..7)
- c_TIMEOUT, 25000, clocks without an edge before the line is declared lost

Ports:
- i_clock  in  1  system clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_led  in  1  LED line under test, asynchronous to i_clock
- o_rate_code  out  2  11 = 1 Hz, 10 = 10 Hz, 01 = 50 Hz, 00 = 100 Hz
- o_valid  out  1  rate locked; o_rate_code is meaningful
- o_lost  out  1  no edge seen for c_TIMEOUT clocks
- o_level  out  1  synchronized line level (meaningful when o_lost = 1)

Behaviour:
- Interface: one clock, i_clock. Reset i_reset_n is asynchronous and active-low.
- Reset values: o_rate_code = 00, o_valid = 0, o_lost = 1, o_level = 0. All internal state is cleared, and FSM = IDLE.
- Synchronizer and edge detect:
  - i_led passes through a 2-flop synchronizer, then a 1-flop delay register.
  - w_edge = sync output XOR delay register.
  - Pin change to w_edge: 2–3 cycles.
  - All outputs are registered and update on the clock after w_edge.
- Counter r_cnt, width $clog2(c_TIMEOUT+1):
  - Cleared to 0 on w_edge.
  - Otherwise increments each cycle, saturating at c_TIMEOUT.
  - Measured half-period H = r_cnt + 1 at w_edge, i.e. the clock distance between edge pulses.
- Classifier:
  - H matches a class if (nominal − (nominal >> c_TOL_SHIFT)) ≤ H ≤ (nominal + (nominal >> c_TOL_SHIFT)).
  - Default windows: [110, 140], [219, 281], [1094, 1406], [10938, 14062].
  - Outside all windows = no-match.
  - Windows do not overlap, so at most one class matches.
- FSM states: IDLE, MEASURE, LOCKED.
  - IDLE:
    - w_edge → MEASURE. No classification is done on this edge.
    - o_lost ← 0.
  - MEASURE, on w_edge, using a matched class:
    - If class == r_cand, r_match ← r_match + 1.
    - Otherwise r_cand ← class and r_match ← 1.
    - When r_match reaches c_LOCK_CNT: go to LOCKED, set o_valid ← 1 and o_rate_code ← r_cand.
  - MEASURE, on w_edge with no-match: r_match ← 0 and stay in MEASURE.
  - LOCKED:
    - w_edge with the same class: stay locked.
    - w_edge with a different class: o_valid ← 0, go to MEASURE, r_cand ← new class, r_match ← 1.
    - w_edge with no-match: o_valid ← 0, go to MEASURE, r_match ← 0.
    - o_rate_code holds its last locked value while o_valid = 0.
- Timeout:
  - Applies in MEASURE or LOCKED, when r_cnt reaches c_TIMEOUT with no w_edge.
  - Next state IDLE, with o_valid ← 0, o_lost ← 1 and r_match ← 0.
- If w_edge and the timeout condition occur in the same cycle, the edge wins.
- o_level tracks the synchronized level every cycle.
- A reset asserted mid-operation returns the block to IDLE immediately. No partial measurement is retained.
- Glitches shorter than one clock may be missed. Glitches that are caught are classified as short H (no-match).

Decomposition:
- Package led_rate_pkg holds:
  - the rate-code typedef, an enum shared with the blinker's switch encoding;
  - the FSM state typedef;
  - the default nominal-count constants.
- Sub-module led_edge_sync holds the 2-flop synchronizer, the delay flop, and the w_edge and level outputs. It is reset by i_reset_n.

Test Plan:
- Square wave, H = 125 clocks:
  - o_lost falls after the 1st edge.
  - o_valid = 1 and o_rate_code = 00 one cycle after the 3rd edge pulse.
- Square wave, H = 12500 → o_rate_code = 11 and o_valid = 1 after the 3rd edge; o_lost stays 0.
- Boundaries:
  - H = 110 and H = 140 lock to 00.
  - H = 109, 141 and 175 never assert o_valid.
- Locked at H = 1250 (code 10), then switch to H = 250:
  - o_valid drops one cycle after the first 250-clock edge.
  - It reasserts with code 01 one cycle after the next edge.
- Locked, then hold i_led = 1 for 25000+ clocks:
  - o_valid = 0, o_lost = 1, o_level = 1.
  - o_rate_code retains its last value.
  - The next toggle clears o_lost.
- Assert i_reset_n = 0 mid-lock → outputs immediately 00/0/1/0. After release, lock requires c_LOCK_CNT fresh matched half-periods.

Source files
------------

// File: rtl/led_rate_pkg.sv
// Shared types and default timing constants for the LED blink-rate decoder.
// Rate codes match the blinker's switch-select encoding.
package led_rate_pkg;

   typedef enum logic [1:0] {
      RATE_100HZ = 2'b00,
      RATE_50HZ  = 2'b01,
      RATE_10HZ  = 2'b10,
      RATE_1HZ   = 2'b11
   } rate_code_t;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_MEASURE = 2'b01,
      ST_LOCKED  = 2'b10
   } state_t;

   localparam int CNT_100HZ_DEF = 125;
   localparam int CNT_50HZ_DEF  = 250;
   localparam int CNT_10HZ_DEF  = 1250;
   localparam int CNT_1HZ_DEF   = 12500;
   localparam int TOL_SHIFT_DEF = 3;
   localparam int LOCK_CNT_DEF  = 2;
   localparam int TIMEOUT_DEF   = 25000;

   function automatic int window_lo(input int nominal, input int tol_shift);
      return nominal - (nominal >> tol_shift);
   endfunction

   function automatic int window_hi(input int nominal, input int tol_shift);
      return nominal + (nominal >> tol_shift);
   endfunction

endpackage

// File: rtl/led_edge_sync.sv
// Brings the asynchronous LED line into the clock domain and flags each
// level change with a one-cycle edge pulse.
module led_edge_sync (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_led,
   output logic o_edge,
   output logic o_level
);

   logic sync1_reg;
   logic sync2_reg;
   logic dly_reg;

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync1_reg <= 1'b0;
         sync2_reg <= 1'b0;
         dly_reg   <= 1'b0;
      end else begin
         sync1_reg <= i_led;
         sync2_reg <= sync1_reg;
         dly_reg   <= sync2_reg;
      end
   end

   assign o_edge  = sync2_reg ^ dly_reg;
   assign o_level = sync2_reg;

endmodule

// File: rtl/led_rate_decoder.sv
// Measures the half-period of an LED drive line and locks onto one of the
// four blinker rates; a line that stops toggling is reported as lost.
module led_rate_decoder
   import led_rate_pkg::*;
#(
   parameter int c_CNT_100HZ = CNT_100HZ_DEF,
   parameter int c_CNT_50HZ  = CNT_50HZ_DEF,
   parameter int c_CNT_10HZ  = CNT_10HZ_DEF,
   parameter int c_CNT_1HZ   = CNT_1HZ_DEF,
   parameter int c_TOL_SHIFT = TOL_SHIFT_DEF,
   parameter int c_LOCK_CNT  = LOCK_CNT_DEF,
   parameter int c_TIMEOUT   = TIMEOUT_DEF
) (
   input  logic       i_clock,
   input  logic       i_reset_n,
   input  logic       i_led,
   output logic [1:0] o_rate_code,
   output logic       o_valid,
   output logic       o_lost,
   output logic       o_level
);

   localparam int CNT_W = $clog2(c_TIMEOUT + 1);
   localparam int H_W   = CNT_W + 1;
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(c_TIMEOUT);
   localparam logic [2:0]       LOCK_VAL    = 3'(c_LOCK_CNT);

   logic w_edge;
   logic sync_level;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   rate_code_t       cand_reg, cand_next;
   logic [2:0]       match_reg, match_next;
   rate_code_t       rate_reg, rate_next;
   logic             valid_reg, valid_next;
   logic             lost_reg, lost_next;
   logic             level_reg;

   logic [H_W-1:0] h_val;
   logic [3:0]     hit;
   logic           hit_any;
   rate_code_t     hit_code;
   logic [2:0]     match_inc;
   logic           timeout;

   led_edge_sync u_edge_sync (
      .i_clock   (i_clock),
      .i_reset_n (i_reset_n),
      .i_led     (i_led),
      .o_edge    (w_edge),
      .o_level   (sync_level)
   );

   // Counter holds H-1 when the edge arrives, so H is one more than its value.
   assign h_val = {1'b0, cnt_reg} + H_W'(1);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_class
         localparam int NOM = (gi == 0) ? c_CNT_100HZ :
                              (gi == 1) ? c_CNT_50HZ  :
                              (gi == 2) ? c_CNT_10HZ  : c_CNT_1HZ;
         localparam logic [H_W-1:0] LO = H_W'(window_lo(NOM, c_TOL_SHIFT));
         localparam logic [H_W-1:0] HI = H_W'(window_hi(NOM, c_TOL_SHIFT));
         assign hit[gi] = (h_val >= LO) && (h_val <= HI);
      end
   endgenerate

   // Windows are disjoint, so hit is at most one-hot and index equals rate code.
   always_comb begin
      hit_any  = |hit;
      hit_code = RATE_100HZ;
      if (hit[1]) hit_code = RATE_50HZ;
      if (hit[2]) hit_code = RATE_10HZ;
      if (hit[3]) hit_code = RATE_1HZ;
   end

   assign match_inc = (hit_code == cand_reg) ? match_reg + 3'd1 : 3'd1;
   assign timeout   = (cnt_reg == TIMEOUT_VAL);

   always_comb begin
      state_next = state_reg;
      cand_next  = cand_reg;
      match_next = match_reg;
      rate_next  = rate_reg;
      valid_next = valid_reg;
      lost_next  = lost_reg;
      if (w_edge)
         cnt_next = '0;
      else if (timeout)
         cnt_next = cnt_reg;
      else
         cnt_next = cnt_reg + CNT_W'(1);

      case (state_reg)
         ST_IDLE: begin
            if (w_edge) begin
               state_next = ST_MEASURE;
               lost_next  = 1'b0;
            end
         end
         ST_MEASURE: begin
            if (w_edge) begin
               if (hit_any) begin
                  cand_next  = hit_code;
                  match_next = match_inc;
                  if (match_inc >= LOCK_VAL) begin
                     state_next = ST_LOCKED;
                     valid_next = 1'b1;
                     rate_next  = hit_code;
                  end
               end else begin
                  match_next = 3'd0;
               end
            end else if (timeout) begin
               state_next = ST_IDLE;
               valid_next = 1'b0;
               lost_next  = 1'b1;
               match_next = 3'd0;
            end
         end
         ST_LOCKED: begin
            if (w_edge) begin
               if (!hit_any) begin
                  state_next = ST_MEASURE;
                  valid_next = 1'b0;
                  match_next = 3'd0;
               end else if (hit_code != cand_reg) begin
                  state_next = ST_MEASURE;
                  valid_next = 1'b0;
                  cand_next  = hit_code;
                  match_next = 3'd1;
               end
            end else if (timeout) begin
               state_next = ST_IDLE;
               valid_next = 1'b0;
               lost_next  = 1'b1;
               match_next = 3'd0;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_reg <= ST_IDLE;
         cnt_reg   <= '0;
         cand_reg  <= RATE_100HZ;
         match_reg <= 3'd0;
         rate_reg  <= RATE_100HZ;
         valid_reg <= 1'b0;
         lost_reg  <= 1'b1;
         level_reg <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         cand_reg  <= cand_next;
         match_reg <= match_next;
         rate_reg  <= rate_next;
         valid_reg <= valid_next;
         lost_reg  <= lost_next;
         level_reg <= sync_level;
      end
   end

   assign o_rate_code = rate_reg;
   assign o_valid     = valid_reg;
   assign o_lost      = lost_reg;
   assign o_level     = level_reg;

endmodule
